wb_regfile_device: RTL and testbench

Pipelined Wishbone B4 device: a small register bank on the device end of the team's `wishbone` interface, answering a `controller` modport instance. It accepts one request per cycle and returns ack/err a fixed `LATENCY` cycles later. It bounds in-flight requests with `stall_o` and abandons in-flight responses when the controller drops `cyc`. It is the first responder on the debug bus, sitting behind the debug-button controller.

---
 rtl/wb_regfile_device.sv | 61 ++++++
 tb/tb_wb_regfile_device.sv | 130 +++++++++++++
 2 files changed

// File: rtl/wb_regfile_device.sv
// wb_regfile_device: pipelined Wishbone register bank with fixed-latency ack/err and bounded outstanding requests
module wb_regfile_device #(
  parameter int DAT_WIDTH = 8,
  parameter int ADR_WIDTH = 4,
  parameter int NUM_REGS = 4,
  parameter logic [DAT_WIDTH-1:0] ID_VALUE = 8'hA5,
  parameter int LATENCY = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [ADR_WIDTH-1:0] adr_i,
  input  logic [DAT_WIDTH-1:0] dat_i,
  output logic [DAT_WIDTH-1:0] dat_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 rty_o,
  output logic                 stall_o
);
  localparam int CW = $clog2(LATENCY + 1);
  logic [DAT_WIDTH-1:0] rf [2**ADR_WIDTH];
  logic [LATENCY-1:0] v, e;
  logic [LATENCY-1:0][DAT_WIDTH-1:0] d;
  logic [CW-1:0] out_cnt;
  logic accept, bad, wr_en, resp_now;
  logic [DAT_WIDTH-1:0] rd_keep;
  assign resp_now = v[LATENCY-1];
  assign stall_o = (out_cnt == CW'(MAX_OUTSTANDING)) & ~resp_now;
  assign accept = cyc_i & stb_i & ~stall_o;
  assign bad = ~({1'b0, adr_i} < (ADR_WIDTH + 1)'(NUM_REGS)) | (we_i & adr_i == '0);
  assign wr_en = accept & we_i & ~bad;
  assign rd_keep = (~we_i & ~bad) ? rf[adr_i] : '0;
  assign ack_o = cyc_i & resp_now & ~e[LATENCY-1];
  assign err_o = cyc_i & resp_now & e[LATENCY-1];
  assign dat_o = ack_o ? d[LATENCY-1] : '0;
  assign rty_o = 1'b0;
  for (genvar i = 0; i < 2**ADR_WIDTH; i++) begin : g_reg
    if (i == 0) begin : g_id
      assign rf[i] = ID_VALUE;
    end else if (i < NUM_REGS) begin : g_rw
      logic [DAT_WIDTH-1:0] q;
      // writable register, committed at the accepting edge unless reset wins
      always_ff @(posedge clk_i)
        if (rst_i) q <= '0;
        else if (wr_en && adr_i == ADR_WIDTH'(i)) q <= dat_i;
      assign rf[i] = q;
    end else begin : g_nc
      assign rf[i] = '0;
    end
  end
  // response shift pipeline and outstanding counter; dropping cyc abandons everything in flight
  always_ff @(posedge clk_i) begin
    v <= (rst_i | ~cyc_i) ? '0 : (v << 1) | LATENCY'(accept);
    e <= (e << 1) | LATENCY'(bad);
    d <= (d << DAT_WIDTH) | (LATENCY * DAT_WIDTH)'(rd_keep);
    out_cnt <= (rst_i | ~cyc_i) ? '0 : out_cnt + CW'(accept) - CW'(resp_now);
  end
endmodule

// File: tb/tb_wb_regfile_device.sv
// tb_wb_regfile_device: randomized transaction-model check of the register bank plus a directed stall run
module tb_wb_regfile_device;
  localparam int LAT = 2;
  localparam int MAXO = 2;
  localparam int NREG = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cyc, stb, we, ack, err, rty, stall;
  logic [3:0] adr;
  logic [7:0] dat_w, dat_r;
  logic s_rst, s_cyc, s_stb, s_we, s_ack, s_err, s_rty, s_stall;
  logic [3:0] s_adr;
  logic [7:0] s_dw, s_dr;
  wb_regfile_device u_dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat_w),
    .dat_o(dat_r), .ack_o(ack), .err_o(err), .rty_o(rty), .stall_o(stall)
  );
  wb_regfile_device #(.LATENCY(3), .MAX_OUTSTANDING(1)) u_stl (
    .clk_i(clk), .rst_i(s_rst), .cyc_i(s_cyc), .stb_i(s_stb), .we_i(s_we), .adr_i(s_adr), .dat_i(s_dw),
    .dat_o(s_dr), .ack_o(s_ack), .err_o(s_err), .rty_o(s_rty), .stall_o(s_stall)
  );
  typedef struct {
    int         due;
    logic       e;
    logic [7:0] d;
  } resp_t;
  resp_t q[$];
  logic [7:0] mem [16];
  logic [7:0] exp_d [4];
  int now, n_vec, n_bad;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic c, input logic s, input logic w,
                      input logic [3:0] a, input logic [7:0] dv);
    logic hit, xs, bd;
    resp_t f, n;
    rst = r; cyc = c; stb = s; we = w; adr = a; dat_w = dv;
    @(negedge clk);
    hit = q.size() > 0 && q[0].due == now;
    f.due = 0; f.e = 1'b0; f.d = 8'h00;
    if (hit) f = q[0];
    xs = q.size() == MAXO && !hit;
    check("ack", ack, c & hit & ~f.e);
    check("err", err, c & hit & f.e);
    check("dat", dat_r, (c & hit & ~f.e) ? f.d : 8'h00);
    check("stall", stall, xs);
    check("rty", rty, 1'b0);
    if (r) begin
      q.delete();
      foreach (mem[i]) mem[i] = 8'h00;
    end else if (!c) begin
      q.delete();
    end else begin
      if (hit) void'(q.pop_front());
      if (s && !xs) begin
        bd = a >= NREG || (w && a == 0);
        n.due = now + LAT;
        n.e = bd;
        n.d = (!bd && !w) ? ((a == 0) ? 8'hA5 : mem[a]) : 8'h00;
        q.push_back(n);
        if (!bd && w) mem[a] = dv;
      end
    end
    @(posedge clk);
    #1;
    now++;
  endtask
  initial begin
    int k;
    n_vec = 0; n_bad = 0; now = 0;
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0;
    s_rst = 1; s_cyc = 0; s_stb = 0; s_we = 0; s_adr = 0; s_dw = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    repeat (10) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 2, 8'h3C);
    step(0, 1, 1, 0, 2, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 8'h55);
    step(0, 1, 1, 0, 7, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0);
    step(0, 1, 1, 0, 2, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 8'h11);
    step(0, 1, 1, 1, 2, 8'h22);
    step(1, 1, 1, 1, 3, 8'h33);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) step(0, 1, 1, 0, 4'(i), 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    repeat (1500)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4)),
           8'($urandom));
    cyc = 0; stb = 0; rst = 0;
    s_rst = 0; s_cyc = 1;
    for (int i = 1; i < 4; i++) begin
      s_stb = 1; s_we = 1; s_adr = 4'(i); s_dw = 8'(8'h11 * i);
      @(posedge clk); #1;
      s_stb = 0; s_we = 0;
      repeat (3) begin @(posedge clk); #1; end
    end
    exp_d[0] = 8'hA5; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33;
    k = 0;
    for (int c = 0; c < 15; c++) begin
      s_stb = k < 4; s_we = 0; s_adr = 4'(k);
      @(negedge clk);
      check("stl_stall", s_stall, c < 12 && c % 3 != 0);
      check("stl_ack", s_ack, c > 0 && c <= 12 && c % 3 == 0);
      check("stl_dat", s_dr, (c > 0 && c <= 12 && c % 3 == 0) ? exp_d[c/3-1] : 8'h00);
      check("stl_err", s_err, 1'b0);
      @(posedge clk); #1;
      if (c % 3 == 0 && k < 4) k++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
